// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ packet sources share one UART transmitter.
// A granted requester keeps the transmitter until its last byte, or until its lock times out.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     err_lock_timeout,
    output logic                     err_busy_timeout
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned LW = $clog2(LOCK_TIMEOUT);
    localparam int unsigned BW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [2:0] {StIdle, StAccept, StStart, StWaitHi, StWaitLo} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            grant_valid_q, grant_valid_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            last_q, last_d;
    logic            err_lock_q, err_lock_d;
    logic            err_busy_q, err_busy_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [BW-1:0]   busy_cnt_q, busy_cnt_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            finish_byte;

    // First valid requester after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IW'((32'(rr_ptr_q) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        err_lock_d    = 1'b0;
        err_busy_d    = 1'b0;
        lock_cnt_d    = lock_cnt_q;
        busy_cnt_d    = busy_cnt_q;
        finish_byte   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A foreign frame on the line holds off arbitration.
                if (found && !tx_busy) begin
                    grant_id_d    = pick;
                    grant_valid_d = 1'b1;
                    lock_cnt_d    = '0;
                    state_d       = StAccept;
                end
            end
            StAccept: begin
                if (req_valid[grant_id_q]) begin
                    tx_data_d  = req_data[{grant_id_q, 3'b000} +: 8];
                    last_d     = req_last[grant_id_q];
                    lock_cnt_d = '0;
                    tx_start_d = 1'b1;
                    state_d    = StStart;
                end else if (lock_cnt_q == LW'(LOCK_TIMEOUT - 1)) begin
                    err_lock_d    = 1'b1;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = grant_id_q;
                    state_d       = StIdle;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            StStart: begin
                // Counts cycles since tx_start, so the START cycle itself is cycle 1.
                busy_cnt_d = BW'(1);
                state_d    = StWaitHi;
            end
            StWaitHi: begin
                if (tx_busy) begin
                    state_d = StWaitLo;
                end else if (busy_cnt_q == BW'(BUSY_TIMEOUT - 1)) begin
                    err_busy_d  = 1'b1;
                    finish_byte = 1'b1;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    finish_byte = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish_byte) begin
            if (last_q) begin
                grant_valid_d = 1'b0;
                rr_ptr_d      = grant_id_q;
                state_d       = StIdle;
            end else begin
                lock_cnt_d = '0;
                state_d    = StAccept;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            rr_ptr_q      <= IW'(N_REQ - 1);
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            last_q        <= 1'b0;
            err_lock_q    <= 1'b0;
            err_busy_q    <= 1'b0;
            lock_cnt_q    <= '0;
            busy_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            err_lock_q    <= err_lock_d;
            err_busy_q    <= err_busy_d;
            lock_cnt_q    <= lock_cnt_d;
            busy_cnt_q    <= busy_cnt_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StAccept) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign tx_start         = tx_start_q;
    assign tx_data          = tx_data_q;
    assign grant_valid      = grant_valid_q;
    assign grant_id         = grant_id_q;
    assign err_lock_timeout = err_lock_q;
    assign err_busy_timeout = err_busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter; legal range 2..8.
REQ-002 Parameter LOCK_TIMEOUT, default 1024: number of idle clk cycles a locked packet may stall before the lock is released.
REQ-003 Parameter BUSY_TIMEOUT, default 8: maximum number of clk cycles from tx_start until tx_busy rises.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester byte available.
REQ-007 req_data  in  8*N_REQ  requester i byte at [8i+7:8i].
REQ-008 req_last  in  N_REQ  byte is the final byte of its packet.
REQ-009 req_ready  out  N_REQ  byte accepted when req_valid[i] & req_ready[i].
REQ-010 tx_start  out  1  one-cycle pulse that launches a byte into the UART TX engine.
REQ-011 tx_data  out  8  byte for the TX engine; stable from tx_start until tx_busy falls.
REQ-012 tx_busy  in  1  TX engine is serialising a frame (start, 8 data, parity, stop).
REQ-013 grant_valid  out  1  a requester currently holds the transmitter.
REQ-014 grant_id  out  clog2(N_REQ)  index of the granted requester.
REQ-015 err_lock_timeout  out  1  one-cycle pulse when a packet lock is force-released.
REQ-016 err_busy_timeout  out  1  one-cycle pulse when tx_busy fails to rise.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCEPT, START, WAIT_HI and WAIT_LO.
REQ-018 IDLE: if any req_valid is high, the block SHALL register grant_id as the first requester with req_valid high, searching round-robin from rr_ptr+1 mod N_REQ, set grant_valid and go to ACCEPT.
REQ-019 ACCEPT: req_ready[grant_id] SHALL be high combinationally and every other req_ready bit low.
REQ-020 ACCEPT: when req_valid[grant_id] is high, the block SHALL latch tx_data and req_last and go to START.
REQ-021 ACCEPT with valid low: the lock counter SHALL increment each cycle.
REQ-022 ACCEPT: when the lock counter reaches LOCK_TIMEOUT-1, the block SHALL pulse err_lock_timeout, clear grant_valid, set rr_ptr=grant_id and go to IDLE.
REQ-023 The lock counter SHALL clear on every accepted byte and on every entry to ACCEPT.
REQ-024 START: tx_start SHALL be high for exactly this one cycle; the next state SHALL be WAIT_HI.
REQ-025 WAIT_HI: the block SHALL go to WAIT_LO when tx_busy=1.
REQ-026 WAIT_HI: if tx_busy stays low for BUSY_TIMEOUT cycles, the block SHALL pulse err_busy_timeout and handle the byte as finished, per REQ-027.
REQ-027 WAIT_LO: when tx_busy=0 and last=1, the block SHALL clear grant_valid, set rr_ptr=grant_id and go to IDLE; when last=0 it SHALL go to ACCEPT keeping the same grant.
REQ-028 Bytes of one packet SHALL never interleave with another requester's bytes; arbitration SHALL occur only in IDLE.
REQ-029 Latency: req_valid rising in IDLE SHALL give req_ready high on the next cycle and tx_start high one cycle after acceptance.
REQ-030 No tx_start SHALL be issued while tx_busy=1; if IDLE sees tx_busy=1 (foreign frame), arbitration SHALL wait.
REQ-031 A requester dropping req_valid while granted SHALL cause no error, only lock-counter stall.
REQ-032 Simultaneous requests SHALL be resolved purely by rr_ptr, so each requester is served within N_REQ packets.

Reset
REQ-033 While rst=1 the block SHALL hold state=IDLE, rr_ptr=N_REQ-1, grant_valid=0, grant_id=0, req_ready=0, tx_start=0, tx_data=0x00, both error outputs 0, and all counters 0.
REQ-034 Reset asserted mid-frame SHALL abort immediately with no tx_start pulse; after release, the next packet SHALL start from requester 0 priority.

Verification
REQ-035 Scenario: only req 2 valid, 1-byte packet 0xA5 with last, TX busy 11 baud periods -> grant_id=2; one tx_start with tx_data=0xA5; then grant_valid=0.
REQ-036 Scenario: reqs 0,1,3 valid with 1-byte packets after reset -> tx order 0,1,3, then 0 again if it re-requests.
REQ-037 Scenario: req 1 sends 3-byte packet 0x11,0x22,0x33 (last on 0x33) while req 0 is valid -> three req-1 bytes contiguous, req 0 served next.
REQ-038 Scenario: tx_busy tied low after tx_start -> err_busy_timeout pulse exactly BUSY_TIMEOUT cycles after tx_start; FSM returns to IDLE/ACCEPT.
REQ-039 Scenario: granted requester drops valid mid-packet for LOCK_TIMEOUT cycles -> err_lock_timeout pulses once, another valid requester is then granted.
REQ-040 Scenario: rst pulsed during WAIT_LO -> all outputs at reset values within the same cycle; no residual tx_start.
